dual_port_arbiter: RTL and testbench

DUAL_PORT_ARBITER -- requirements
Module: dual_port_arbiter

---
 rtl/dual_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_dual_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dual_port_arbiter.sv
// Two-requester round-robin arbiter onto a single registered valid/ready channel.
// Grants are held for up to MAX_BURST beats; per-requester beat counters saturate.
module dual_port_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_src_o,
    input  logic              clr_cnt_i,
    output logic [15:0]       a_cnt_o,
    output logic [15:0]       b_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t              state_r;
    logic [3:0]          burst_r;
    logic                last_src_r;
    logic                m_valid_r;
    logic [DATA_W-1:0]   m_data_r;
    logic                m_src_r;
    logic [15:0]         a_cnt_r;
    logic [15:0]         b_cnt_r;

    logic load_en_s, a_gnt_s, b_gnt_s, a_xfer_s, b_xfer_s, xfer_s;
    logic gnt_valid_s, oth_valid_s, burst_end_s, release_s;

    // Handshake decode: ready only toward the granted side, and only when the output slot frees up.
    always_comb begin
        load_en_s = ~m_valid_r | m_ready_i;
        a_gnt_s   = (state_r == GNT_A);
        b_gnt_s   = (state_r == GNT_B);
        a_ready_o = a_gnt_s & load_en_s;
        b_ready_o = b_gnt_s & load_en_s;
        a_xfer_s  = a_valid_i & a_ready_o;
        b_xfer_s  = b_valid_i & b_ready_o;
        xfer_s    = a_xfer_s | b_xfer_s;
        if (a_gnt_s) begin
            gnt_valid_s = a_valid_i;
            oth_valid_s = b_valid_i;
        end else if (b_gnt_s) begin
            gnt_valid_s = b_valid_i;
            oth_valid_s = a_valid_i;
        end else begin
            gnt_valid_s = 1'b0;
            oth_valid_s = 1'b0;
        end
        burst_end_s = xfer_s & (burst_r == BURST_LAST);
        release_s   = (a_gnt_s | b_gnt_s) & (burst_end_s | ~gnt_valid_s);
    end

    // Grant FSM with burst counting and round-robin tie memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            burst_r    <= 4'd0;
            last_src_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    // last_src_r = 1 means B won last, so A takes a tie.
                    if (a_valid_i & (~b_valid_i | last_src_r)) begin
                        state_r    <= GNT_A;
                        last_src_r <= 1'b0;
                        burst_r    <= 4'd0;
                    end else if (b_valid_i) begin
                        state_r    <= GNT_B;
                        last_src_r <= 1'b1;
                        burst_r    <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_A, GNT_B: begin
                    if (release_s) begin
                        if (oth_valid_s) begin
                            state_r    <= (state_r == GNT_A) ? GNT_B : GNT_A;
                            last_src_r <= (state_r == GNT_A);
                            burst_r    <= 4'd0;
                        end else if (gnt_valid_s) begin
                            state_r    <= state_r;
                            last_src_r <= (state_r == GNT_B);
                            burst_r    <= 4'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (xfer_s) begin
                        burst_r <= burst_r + 4'd1;
                    end else begin
                        burst_r <= burst_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    burst_r <= 4'd0;
                end
            endcase
        end
    end

    // Output register slot: loads on transfer, empties once the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_src_r   <= 1'b0;
        end else if (xfer_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= a_xfer_s ? a_data_i : b_data_i;
            m_src_r   <= b_xfer_s;
        end else if (m_ready_i) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Saturating beat counters; clear wins over a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_r <= 16'd0;
            b_cnt_r <= 16'd0;
        end else if (clr_cnt_i) begin
            a_cnt_r <= 16'd0;
            b_cnt_r <= 16'd0;
        end else begin
            if (a_xfer_s && (a_cnt_r != 16'hFFFF)) a_cnt_r <= a_cnt_r + 16'd1;
            else                                   a_cnt_r <= a_cnt_r;
            if (b_xfer_s && (b_cnt_r != 16'hFFFF)) b_cnt_r <= b_cnt_r + 16'd1;
            else                                   b_cnt_r <= b_cnt_r;
        end
    end

    assign m_valid_o = m_valid_r;
    assign m_data_o  = m_data_r;
    assign m_src_o   = m_src_r;
    assign a_cnt_o   = a_cnt_r;
    assign b_cnt_o   = b_cnt_r;

endmodule

// File: tb/tb_dual_port_arbiter.sv
// Directed bench for dual_port_arbiter: scoreboard of accepted beats plus
// checks of reset, grant order, backpressure, release and counter saturation.
module tb_dual_port_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid_i, b_valid_i, m_ready_i, clr_cnt_i;
    logic          a_ready_o, b_ready_o, m_valid_o, m_src_o;
    logic [DW-1:0] a_data_i, b_data_i, m_data_o;
    logic [15:0]   a_cnt_o, b_cnt_o;

    dual_port_arbiter #(.DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_src_o(m_src_o), .clr_cnt_i(clr_cnt_i),
        .a_cnt_o(a_cnt_o), .b_cnt_o(b_cnt_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] sb[$];
    logic [DW-1:0] a_base, a_step, b_base, b_step;
    int          a_idx, b_idx, a_beats, b_beats;
    logic        acc_v, acc_src_v;
    int          nb;
    logic        seen_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive source data, retire/record handshakes, then check 1-cycle latency.
    task automatic cycle();
        logic [DW:0]   exp_beat;
        logic [DW-1:0] d;
        a_data_i = a_base + a_step * DW'(a_idx);
        b_data_i = b_base + b_step * DW'(b_idx);
        #1;
        chk("ready_excl", {31'd0, a_ready_o & b_ready_o}, 32'd0);
        if (m_valid_o && m_ready_i) begin
            chk("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_beat = sb.pop_front();
                chk("sb_order", {23'd0, m_src_o, m_data_o}, {23'd0, exp_beat});
            end
        end
        acc_v = 1'b0;
        acc_src_v = 1'b0;
        d = '0;
        if (a_valid_i && a_ready_o) begin
            acc_v = 1'b1; acc_src_v = 1'b0; d = a_data_i; a_idx++; a_beats++;
        end
        if (b_valid_i && b_ready_o) begin
            acc_v = 1'b1; acc_src_v = 1'b1; d = b_data_i; b_idx++; b_beats++;
        end
        if (acc_v) sb.push_back({acc_src_v, d});
        @(posedge clk);
        #1;
        if (acc_v) chk("latency", {22'd0, m_valid_o, m_src_o, m_data_o}, {22'd0, 1'b1, acc_src_v, d});
    endtask

    initial begin
        rst_n = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; m_ready_i = 1'b1; clr_cnt_i = 1'b0;
        a_data_i = '0; b_data_i = '0;
        a_base = 8'h11; a_step = 8'h11; b_base = 8'hB0; b_step = 8'h01;
        a_idx = 0; b_idx = 0; a_beats = 0; b_beats = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_m_data", {24'd0, m_data_o}, 32'd0);
        chk("rst_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);
        chk("rst_cnt", {a_cnt_o, b_cnt_o}, 32'd0);
        rst_n = 1'b1;

        // A alone, 6 beats 0x11..0x66, no bubble at the burst boundary
        a_valid_i = 1'b1;
        cycle();
        chk("a_idle_gap", {31'd0, acc_v}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("a_stream", {30'd0, acc_v, acc_src_v}, {30'd0, 1'b1, 1'b0});
        end
        a_valid_i = 1'b0;
        cycle(); cycle();
        chk("a_cnt_6", {16'd0, a_cnt_o}, 32'd6);

        // Reset mid-stream, release with both requesters valid
        a_base = 8'hA0; a_step = 8'h01; a_idx = 0;
        a_valid_i = 1'b1;
        cycle(); cycle(); cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_m", {29'd0, m_valid_o, m_src_o, |m_data_o}, 32'd0);
        chk("midrst_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);
        chk("midrst_cnt", {a_cnt_o, b_cnt_o}, 32'd0);
        sb.delete();
        a_idx = 0; b_idx = 0; a_beats = 0; b_beats = 0;
        b_valid_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("rr_idle_gap", {31'd0, acc_v}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            cycle();
            chk("rr_pattern", {30'd0, acc_v, acc_src_v}, {30'd0, 1'b1, ((k / 4) % 2) == 1});
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        cycle(); cycle();
        chk("rr_cnt", {a_cnt_o, b_cnt_o}, {16'd8, 16'd8});

        // Backpressure with 0x5A held in the output slot
        a_base = 8'h5A; a_idx = 0; m_ready_i = 1'b0;
        a_valid_i = 1'b1;
        cycle();
        cycle();
        chk("bp_accept", {30'd0, acc_v, acc_src_v}, {30'd0, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold", {22'd0, m_valid_o, m_src_o, m_data_o}, {22'd0, 1'b1, 1'b0, 8'h5A});
            chk("bp_ready", {30'd0, a_ready_o, b_ready_o}, 32'd0);
        end
        m_ready_i = 1'b1;
        cycle();
        chk("bp_drain", {24'd0, m_data_o}, {24'd0, 8'h5B});
        a_valid_i = 1'b0;
        cycle();
        chk("m_valid_clear", {31'd0, m_valid_o}, 32'd0);
        cycle();

        // A drops valid after 2 beats while B waits
        a_base = 8'hC0; a_idx = 0; b_base = 8'hD0; b_idx = 0;
        a_valid_i = 1'b1;
        cycle();
        b_valid_i = 1'b1;
        cycle(); cycle();
        a_valid_i = 1'b0;
        cycle();
        chk("switch_b", {30'd0, a_ready_o, b_ready_o}, {30'd0, 1'b0, 1'b1});
        a_valid_i = 1'b1;
        nb = 0; seen_a = 1'b0;
        for (int i = 0; i < 12 && !seen_a; i++) begin
            cycle();
            if (acc_v) begin
                if (acc_src_v) nb++;
                else seen_a = 1'b1;
            end
        end
        chk("b_full_burst", nb, 32'd4);
        chk("a_regrant", {31'd0, seen_a}, 32'd1);
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        cycle(); cycle();
        chk("a_cnt_total", {16'd0, a_cnt_o}, a_beats);

        // B counter saturation then synchronous clear
        b_valid_i = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        b_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        chk("b_cnt_sat", {16'd0, b_cnt_o}, 32'h0000FFFF);
        b_valid_i = 1'b1;
        cycle();
        clr_cnt_i = 1'b1;
        cycle();
        chk("clr_with_xfer", {31'd0, acc_v}, 32'd1);
        chk("clr_cnt", {a_cnt_o, b_cnt_o}, 32'd0);
        clr_cnt_i = 1'b0;
        cycle();
        chk("cnt_after_clr", {16'd0, b_cnt_o}, 32'd1);
        b_valid_i = 1'b0;
        cycle(); cycle();
        chk("sb_empty", sb.size(), 32'd0);
        chk("end_idle", {31'd0, m_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
